score_ctrl: RTL and testbench

Scoring stage downstream of the judgement controller in the rhythm-game top level. Consumes one-cycle judgement strobes plus game start/end/restart events, accumulates score, current combo and max combo, and tracks full-combo status. Runs an iterative binary-to-BCD converter so the LCD stage can print the score as six decimal digits without dividers.

---
 rtl/score_ctrl.sv | 155 +++++++++++++++
 tb/tb_score_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/score_ctrl.sv
// Score/combo accumulator with FSM and double-dabble BCD; counters update 1 cycle after strobe, BCD ~22 cycles later.
// No backpressure: strobes are always consumed; optional COMBO_BONUS_EN adds +10 per hit at combo >= 10.
module score_ctrl #(
  parameter int P_PERFECT = 100,
  parameter int P_GOOD    = 50,
  parameter int SCORE_MAX = 999999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_restart,
  input  logic        i_game_end,
  input  logic        i_judge_vld,
  input  logic [1:0]  i_judge,
  output logic [1:0]  o_state,
  output logic [19:0] o_score,
  output logic [9:0]  o_combo,
  output logic [9:0]  o_max_combo,
  output logic        o_full_combo,
  output logic [23:0] o_score_bcd,
  output logic        o_bcd_busy
);

  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_PLAY    = 2'd1;
  localparam logic [1:0]  ST_RESULT  = 2'd2;
  localparam logic [9:0]  COMBO_MAX  = 10'd999;
  localparam logic [20:0] SCORE_CEIL = 21'(SCORE_MAX);
  localparam logic [4:0]  DD_STEPS   = 5'd20;

  logic [1:0]  state, state_nxt;
  logic [19:0] score;
  logic [9:0]  combo, max_combo;
  logic        miss_flag, judged_flag;

  logic        clear, judge_en, hit, score_wr;
  logic [9:0]  combo_hit;
  logic [20:0] pts, bonus, score_sum;
  logic [19:0] score_sat;

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    if (i_restart) begin
      state_nxt = ST_IDLE;
      clear     = 1'b1;
    end else if (i_start && state != ST_PLAY) begin
      state_nxt = ST_PLAY;
      clear     = 1'b1;
    end else if (i_game_end && state == ST_PLAY) begin
      state_nxt = ST_RESULT;
    end
  end

  assign judge_en  = i_judge_vld && (state == ST_PLAY) && !i_restart;
  assign hit       = (i_judge == 2'd1) || (i_judge == 2'd2);
  assign combo_hit = (combo >= COMBO_MAX) ? COMBO_MAX : combo + 10'd1;
  assign pts       = (i_judge == 2'd2) ? 21'(P_PERFECT) : 21'(P_GOOD);

`ifdef COMBO_BONUS_EN
  assign bonus = (combo_hit >= 10'd10) ? 21'd10 : 21'd0;
`else
  assign bonus = 21'd0;
`endif

  assign score_sum = {1'b0, score} + pts + bonus;
  assign score_sat = (score_sum > SCORE_CEIL) ? SCORE_CEIL[19:0] : score_sum[19:0];
  assign score_wr  = clear || (judge_en && hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      score       <= '0;
      combo       <= '0;
      max_combo   <= '0;
      miss_flag   <= 1'b0;
      judged_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        score       <= '0;
        combo       <= '0;
        max_combo   <= '0;
        miss_flag   <= 1'b0;
        judged_flag <= 1'b0;
      end else if (judge_en) begin
        judged_flag <= 1'b1;
        if (hit) begin
          score     <= score_sat;
          combo     <= combo_hit;
          max_combo <= (combo_hit > max_combo) ? combo_hit : max_combo;
        end else begin
          combo     <= '0;
          miss_flag <= 1'b1;
        end
      end
    end
  end

  // Converter works on a snapshot so o_score_bcd only ever shows a complete result.
  logic        pending, busy;
  logic [4:0]  dd_cnt;
  logic [19:0] dd_bin;
  logic [23:0] dd_bcd, dd_adj, bcd_out;

  always_comb begin
    dd_adj = dd_bcd;
    for (int i = 0; i < 6; i++) begin
      if (dd_adj[4*i +: 4] >= 4'd5)
        dd_adj[4*i +: 4] = dd_adj[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      busy    <= 1'b0;
      dd_cnt  <= '0;
      dd_bin  <= '0;
      dd_bcd  <= '0;
      bcd_out <= '0;
    end else begin
      if (!busy) begin
        if (pending) begin
          dd_bin <= score;
          dd_bcd <= '0;
          dd_cnt <= '0;
          busy   <= 1'b1;
        end
      end else if (dd_cnt == DD_STEPS) begin
        bcd_out <= dd_bcd;
        busy    <= 1'b0;
      end else begin
        dd_bcd <= {dd_adj[22:0], dd_bin[19]};
        dd_bin <= {dd_bin[18:0], 1'b0};
        dd_cnt <= dd_cnt + 5'd1;
      end

      // A request landing on the load edge stays pending for a follow-up pass.
      if (score_wr)
        pending <= 1'b1;
      else if (!busy && pending)
        pending <= 1'b0;
    end
  end

  assign o_state      = state;
  assign o_score      = score;
  assign o_combo      = combo;
  assign o_max_combo  = max_combo;
  assign o_full_combo = (state == ST_RESULT) && judged_flag && !miss_flag;
  assign o_score_bcd  = bcd_out;
  assign o_bcd_busy   = busy;

endmodule

// File: tb/tb_score_ctrl.sv
// Scoreboard bench for score_ctrl: stimulus queues expected snapshots, a negedge monitor compares them.
module tb_score_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0, i_restart = 1'b0, i_game_end = 1'b0, i_judge_vld = 1'b0;
  logic [1:0]  i_judge = 2'd0;
  logic [1:0]  o_state;
  logic [19:0] o_score;
  logic [9:0]  o_combo, o_max_combo;
  logic        o_full_combo, o_bcd_busy;
  logic [23:0] o_score_bcd;

  score_ctrl dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_restart(i_restart),
    .i_game_end(i_game_end), .i_judge_vld(i_judge_vld), .i_judge(i_judge),
    .o_state(o_state), .o_score(o_score), .o_combo(o_combo),
    .o_max_combo(o_max_combo), .o_full_combo(o_full_combo),
    .o_score_bcd(o_score_bcd), .o_bcd_busy(o_bcd_busy)
  );

  always #5 clk = ~clk;

`ifdef COMBO_BONUS_EN
  localparam logic [19:0] T3_SCORE = 20'd1230;
  localparam logic [23:0] T3_BCD   = 24'h001230;
  localparam logic [19:0] T5_PRE   = 20'd999999;
`else
  localparam logic [19:0] T3_SCORE = 20'd1200;
  localparam logic [23:0] T3_BCD   = 24'h001200;
  localparam logic [19:0] T5_PRE   = 20'd999500;
`endif

  // kind 0: counters at next negedge; 1: counters + BCD/busy at next negedge; 2: BCD once converter settles
  typedef struct {
    int          kind;
    string       name;
    logic [1:0]  st;
    logic [19:0] sc;
    logic [9:0]  cb;
    logic [9:0]  mx;
    logic        fc;
    logic [23:0] bcd;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input int kind, input string name, input logic [1:0] st,
                      input logic [19:0] sc, input logic [9:0] cb, input logic [9:0] mx,
                      input logic fc, input logic [23:0] bcd, input logic busy);
    exp_t e;
    e.kind = kind; e.name = name; e.st = st; e.sc = sc; e.cb = cb; e.mx = mx;
    e.fc = fc; e.bcd = bcd; e.busy = busy;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 400) begin
      cyc();
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d entries left, want 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    bit   ok;
    int   quiet, waited;
    quiet  = 0;
    waited = 0;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].kind != 2) begin
        e  = sb.pop_front();
        ok = (o_state === e.st) && (o_score === e.sc) && (o_combo === e.cb) &&
             (o_max_combo === e.mx) && (o_full_combo === e.fc);
        if (e.kind == 1)
          ok = ok && (o_score_bcd === e.bcd) && (o_bcd_busy === e.busy);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL %s: got st=%0d score=%0d combo=%0d max=%0d fc=%b bcd=%h busy=%b; want st=%0d score=%0d combo=%0d max=%0d fc=%b bcd=%h busy=%b",
                   e.name, o_state, o_score, o_combo, o_max_combo, o_full_combo, o_score_bcd, o_bcd_busy,
                   e.st, e.sc, e.cb, e.mx, e.fc, e.bcd, e.busy);
        end
      end
      if (sb.size() > 0 && sb[0].kind == 2) begin
        waited++;
        quiet = o_bcd_busy ? 0 : quiet + 1;
        if (quiet >= 2 || waited > 300) begin
          e = sb.pop_front();
          checks++;
          if (quiet < 2 || o_score_bcd !== e.bcd) begin
            errors++;
            $display("FAIL %s: got bcd=%h busy=%b after %0d cycles; want bcd=%h settled",
                     e.name, o_score_bcd, o_bcd_busy, waited, e.bcd);
          end
          quiet  = 0;
          waited = 0;
        end
      end
    end
  end

  // Stimulus
  initial begin
    cyc();
    push(1, "reset", 2'd0, 20'd0, 10'd0, 10'd0, 1'b0, 24'h0, 1'b0);
    cyc();
    rst = 1'b0;
    cyc();

    // 3x PERFECT + GOOD
    i_start = 1'b1; cyc(); i_start = 1'b0;
    push(0, "start_clear", 2'd1, 20'd0, 10'd0, 10'd0, 1'b0, 24'h0, 1'b0);
    i_judge_vld = 1'b1; i_judge = 2'd2;
    repeat (3) cyc();
    i_judge = 2'd1; cyc(); i_judge_vld = 1'b0;
    push(0, "t1_counts", 2'd1, 20'd350, 10'd4, 10'd4, 1'b0, 24'h0, 1'b0);
    push(2, "t1_bcd", 2'd0, 20'd0, 10'd0, 10'd0, 1'b0, 24'h000350, 1'b0);
    drain();

    // Isolated GOOD: exact converter latency
    i_judge_vld = 1'b1; i_judge = 2'd1; cyc(); i_judge_vld = 1'b0;
    push(0, "lat_counts", 2'd1, 20'd400, 10'd5, 10'd5, 1'b0, 24'h0, 1'b0);
    repeat (21) cyc();
    push(1, "lat_busy_e21", 2'd1, 20'd400, 10'd5, 10'd5, 1'b0, 24'h000350, 1'b1);
    cyc();
    push(1, "lat_done_e22", 2'd1, 20'd400, 10'd5, 10'd5, 1'b0, 24'h000400, 1'b0);
    cyc();

    i_game_end = 1'b1; cyc(); i_game_end = 1'b0;
    push(0, "result_fc", 2'd2, 20'd400, 10'd5, 10'd5, 1'b1, 24'h0, 1'b0);
    i_judge_vld = 1'b1; i_judge = 2'd2; cyc(); i_judge_vld = 1'b0;
    push(0, "judge_in_result", 2'd2, 20'd400, 10'd5, 10'd5, 1'b1, 24'h0, 1'b0);

    // 5x GOOD, MISS, 2x PERFECT (last one with game_end)
    i_start = 1'b1; cyc(); i_start = 1'b0;
    push(0, "restart_from_result", 2'd1, 20'd0, 10'd0, 10'd0, 1'b0, 24'h0, 1'b0);
    i_judge_vld = 1'b1; i_judge = 2'd1;
    repeat (5) cyc();
    i_judge = 2'd0; cyc();
    i_judge = 2'd2; cyc();
    i_game_end = 1'b1; cyc();
    i_game_end = 1'b0; i_judge_vld = 1'b0;
    push(0, "t2_miss_game", 2'd2, 20'd450, 10'd2, 10'd5, 1'b0, 24'h0, 1'b0);
    push(2, "t2_bcd", 2'd0, 20'd0, 10'd0, 10'd0, 1'b0, 24'h000450, 1'b0);
    drain();

    // 12x PERFECT, full combo
    i_start = 1'b1; cyc(); i_start = 1'b0;
    i_judge_vld = 1'b1; i_judge = 2'd2;
    repeat (12) cyc();
    i_judge_vld = 1'b0;
    i_game_end = 1'b1; cyc(); i_game_end = 1'b0;
    push(0, "t3_full_combo", 2'd2, T3_SCORE, 10'd12, 10'd12, 1'b1, 24'h0, 1'b0);
    push(2, "t3_bcd", 2'd0, 20'd0, 10'd0, 10'd0, 1'b0, T3_BCD, 1'b0);
    drain();

    // restart wins over a same-cycle judgement; IDLE ignores strobes
    i_start = 1'b1; cyc(); i_start = 1'b0;
    i_judge_vld = 1'b1; i_judge = 2'd2; cyc();
    push(0, "t4_one_hit", 2'd1, 20'd100, 10'd1, 10'd1, 1'b0, 24'h0, 1'b0);
    i_restart = 1'b1; cyc(); i_restart = 1'b0;
    push(0, "t4_restart_judge", 2'd0, 20'd0, 10'd0, 10'd0, 1'b0, 24'h0, 1'b0);
    i_judge = 2'd1; i_game_end = 1'b1; cyc();
    i_judge_vld = 1'b0; i_game_end = 1'b0;
    push(0, "t4_idle_ignore", 2'd0, 20'd0, 10'd0, 10'd0, 1'b0, 24'h0, 1'b0);
    push(2, "t4_bcd_zero", 2'd0, 20'd0, 10'd0, 10'd0, 1'b0, 24'h000000, 1'b0);
    drain();

    // Saturation of score and combo
    i_start = 1'b1; cyc(); i_start = 1'b0;
    i_judge_vld = 1'b1; i_judge = 2'd2;
    repeat (9995) cyc();
    push(0, "t5_preload", 2'd1, T5_PRE, 10'd999, 10'd999, 1'b0, 24'h0, 1'b0);
    repeat (10) cyc();
    i_judge_vld = 1'b0;
    push(0, "t5_saturated", 2'd1, 20'd999999, 10'd999, 10'd999, 1'b0, 24'h0, 1'b0);
    i_game_end = 1'b1; cyc(); i_game_end = 1'b0;
    push(0, "t5_result", 2'd2, 20'd999999, 10'd999, 10'd999, 1'b1, 24'h0, 1'b0);
    push(2, "t5_bcd", 2'd0, 20'd0, 10'd0, 10'd0, 1'b0, 24'h999999, 1'b0);
    drain();

    // Async reset during a conversion
    i_start = 1'b1; cyc(); i_start = 1'b0;
    i_judge_vld = 1'b1; i_judge = 2'd2;
    repeat (2) cyc();
    i_judge_vld = 1'b0;
    push(1, "t6_busy", 2'd1, 20'd200, 10'd2, 10'd2, 1'b0, 24'h999999, 1'b1);
    cyc();
    rst = 1'b1;
    push(1, "t6_async_rst", 2'd0, 20'd0, 10'd0, 10'd0, 1'b0, 24'h0, 1'b0);
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    push(1, "t6_after_rst", 2'd0, 20'd0, 10'd0, 10'd0, 1'b0, 24'h0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
